hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised Tuse/Tnew hazard unit for the pipelined MIPS core, driven by per-stage scoreboard state.
//  - Tracks destination and Tnew of every in-flight instruction in NSTAGE post-decode stages (E,M,W,...).
//  - Drives D-stage stall and D/E forwarding selects.
//  - Counts mult/div latency itself, so no external Busy/Start is needed.
// PARAMETERS
//  NSTAGE   3   post-D stages tracked; stage 1 = E, stage NSTAGE = W
//  AW       5   register address width
//  TW       2   Tnew/Tuse field width
//  SELW     2   forwarding select width; 2**SELW > NSTAGE
//  MUL_LAT  5   cycles of busy after mult/multu enters E
//  DIV_LAT  10  cycles of busy after div/divu enters E
// PORTS
//  clk        in   1     clock
//  reset_n    in   1     synchronous, active-low reset
//  d_valid    in   1     real instruction in D (0 = bubble)
//  d_a1       in   AW    rs address read in D
//  d_a2       in   AW    rt address read in D
//  d_use_rs   in   1     instruction reads rs
//  d_tuse_rs  in   TW    cycles until rs is needed (0 = in D)
//  d_use_rt   in   1     instruction reads rt
//  d_tuse_rt  in   TW    cycles until rt is needed
//  d_a3       in   AW    destination register; 0 = none
//  d_tnew     in   TW    cycles after entering E until the result exists
//  d_md_use   in   1     instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
//  d_md_start in   1     instruction starts the MD unit
//  d_md_div   in   1     the start is a divide (selects DIV_LAT)
//  stall      out  1     freeze PC/IF-D and insert a bubble into E
//  fwd_rs_d   out  SELW  rs source for D: 0 = GRF, k = stage k
//  fwd_rt_d   out  SELW  rt source for D: 0 = GRF, k = stage k
//  fwd_rs_e   out  SELW  rs source for E: 0 = pipeline register, k = stage k (k>=2)
//  fwd_rt_e   out  SELW  rt source for E: 0 = pipeline register, k = stage k (k>=2)
//  md_busy    out  1     MD counter nonzero
// BEHAVIOUR
//  - Stage entries hold {v, a1, a2, a3, tnew}.
//  - Each clk:
//    - stage1 <= stall ? bubble(v=0) : {d_valid, d_a1, d_a2, d_a3, d_tnew}
//    - stage k <= stage k-1 for k>=2; the last stage retires
//    - tnew decrements, saturating at 0, on every move between stages
//  - Match(k,r): v_k && a3_k==r && r!=0. Youngest match = lowest k; older matches are shadowed.
//  - Stall rs: d_valid && d_use_rs && youngest match k exists && tnew_k > d_tuse_rs. Stall rt is the same on rt.
//  - Stall md: d_valid && d_md_use && (md_busy || stage1 holds an MD start).
//  - stall = rs | rt | md. It is combinational from registered state and D inputs, with zero-cycle latency.
//  - fwd_*_d = k if the youngest match k has tnew_k==0, else 0.
//    - When tnew_k > 0 and no stall results, D reads don't-care; the E-stage forward corrects it.
//  - fwd_*_e: the stage-1 operand is matched against stages 2..NSTAGE.
//    - Select the youngest match with tnew==0, else 0.
//    - Bubble or address 0 gives 0.
//  - MD counter:
//    - Loads MUL_LAT or DIV_LAT in the cycle an MD start sits in stage1 (the cycle after leaving D).
//    - Otherwise decrements to 0.
//    - md_busy = (cnt != 0).
//    - A start while busy cannot occur, because it is stalled.
//  - Reset (any cycle, including mid-divide):
//    - all v=0, cnt=0
//    - stall=0 unless md stall terms apply (none after reset)
//    - all fwd=0, md_busy=0
//  - Tnew arithmetic saturates at 0. A Tuse compare against an unsigned TW-bit value is never stale.
// CONFIGURATION
//  HAZARD_STATS_EN
//    - Defined: adds outputs stall_cycles[31:0] and md_stall_cycles[31:0].
//      - Each counts clk cycles with stall (resp. the md term) asserted.
//      - Both saturate at 32'hFFFFFFFF and clear on reset.
//    - Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  - lw $1 in E (tnew=2), D: addu with rs=$1, tuse=1 -> stall=1 for 1 cycle.
//    - Next cycle the lw is in M (tnew=1): no stall.
//    - At E, fwd_rs_e=3 when the lw reaches W.
//  - beq $2 in D (tuse=0) behind addu $2 in M (tnew=0) -> stall=0, fwd_rs_d=2.
//    - Same with addu $2 also in E (tnew=1) -> stall=1 (youngest wins).
//  - jal in E (a3=31, tnew=0), D: jr $31 -> stall=0, fwd_rs_d=1.
//  - A3=0 writer vs rs=0 reader -> never stall, fwd=0.
//  - div in D, mflo follows:
//    - mflo stalls for the 1 cycle the div is in stage1, then for DIV_LAT=10 busy cycles.
//    - md_busy falls after 10 cycles, then stall=0.
//  - reset_n=0 during the 4th busy cycle -> next cycle md_busy=0, all fwd=0, stall=0.
//    - HAZARD_STATS_EN counters read 0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: per-stage destination/Tnew tracking, D stall, D/E forward selects, MD latency counter.
// Optional macro HAZARD_STATS_EN adds saturating stall_cycles / md_stall_cycles counters.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int SELW    = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            d_valid,
  input  logic [AW-1:0]   d_a1,
  input  logic [AW-1:0]   d_a2,
  input  logic            d_use_rs,
  input  logic [TW-1:0]   d_tuse_rs,
  input  logic            d_use_rt,
  input  logic [TW-1:0]   d_tuse_rt,
  input  logic [AW-1:0]   d_a3,
  input  logic [TW-1:0]   d_tnew,
  input  logic            d_md_use,
  input  logic            d_md_start,
  input  logic            d_md_div,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_d,
  output logic [SELW-1:0] fwd_rt_d,
  output logic [SELW-1:0] fwd_rs_e,
  output logic [SELW-1:0] fwd_rt_e,
  output logic            md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     md_stall_cycles
`endif
);

  localparam int MDMAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW    = $clog2(MDMAX + 1);

  logic            v_q    [1:NSTAGE];
  logic [AW-1:0]   a3_q   [1:NSTAGE];
  logic [TW-1:0]   tnew_q [1:NSTAGE];
  // Source operands and MD flags are only ever consulted while in stage 1.
  logic [AW-1:0]   e_a1_q, e_a2_q;
  logic            e_md_start_q, e_md_div_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            s1_v_d, s1_md_start_d;

  logic            rs_hit, rt_hit, e_rs_hit, e_rt_hit;
  logic [SELW-1:0] rs_sel, rt_sel, e_rs_sel, e_rt_sel;
  logic [TW-1:0]   rs_tn, rt_tn, e_rs_tn, e_rt_tn;
  logic            stall_rs, stall_rt, stall_md;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Scan oldest to youngest so the youngest match overwrites (shadows) older ones.
  always_comb begin
    rs_hit   = 1'b0; rs_sel   = '0; rs_tn   = '0;
    rt_hit   = 1'b0; rt_sel   = '0; rt_tn   = '0;
    e_rs_hit = 1'b0; e_rs_sel = '0; e_rs_tn = '0;
    e_rt_hit = 1'b0; e_rt_sel = '0; e_rt_tn = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (v_q[k] && (a3_q[k] == d_a1) && (d_a1 != '0)) begin
        rs_hit = 1'b1; rs_sel = SELW'(k); rs_tn = tnew_q[k];
      end
      if (v_q[k] && (a3_q[k] == d_a2) && (d_a2 != '0)) begin
        rt_hit = 1'b1; rt_sel = SELW'(k); rt_tn = tnew_q[k];
      end
    end
    for (int k = NSTAGE; k >= 2; k--) begin
      if (v_q[k] && (a3_q[k] == e_a1_q) && (e_a1_q != '0)) begin
        e_rs_hit = 1'b1; e_rs_sel = SELW'(k); e_rs_tn = tnew_q[k];
      end
      if (v_q[k] && (a3_q[k] == e_a2_q) && (e_a2_q != '0)) begin
        e_rt_hit = 1'b1; e_rt_sel = SELW'(k); e_rt_tn = tnew_q[k];
      end
    end
  end

  assign md_busy  = (cnt_q != '0);
  assign stall_rs = d_valid && d_use_rs && rs_hit && (rs_tn > d_tuse_rs);
  assign stall_rt = d_valid && d_use_rt && rt_hit && (rt_tn > d_tuse_rt);
  assign stall_md = d_valid && d_md_use && (md_busy || (v_q[1] && e_md_start_q));
  assign stall    = stall_rs || stall_rt || stall_md;

  assign fwd_rs_d = (rs_hit && (rs_tn == '0)) ? rs_sel : '0;
  assign fwd_rt_d = (rt_hit && (rt_tn == '0)) ? rt_sel : '0;
  assign fwd_rs_e = (v_q[1] && e_rs_hit && (e_rs_tn == '0)) ? e_rs_sel : '0;
  assign fwd_rt_e = (v_q[1] && e_rt_hit && (e_rt_tn == '0)) ? e_rt_sel : '0;

  assign s1_v_d        = d_valid && !stall;
  assign s1_md_start_d = s1_v_d && d_md_start;

  always_comb begin
    cnt_d = cnt_q;
    if (v_q[1] && e_md_start_q) begin
      cnt_d = e_md_div_q ? CW'(DIV_LAT) : CW'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= NSTAGE; k++) begin
        v_q[k]    <= 1'b0;
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
      e_a1_q       <= '0;
      e_a2_q       <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      v_q[1]       <= s1_v_d;
      a3_q[1]      <= s1_v_d ? d_a3   : '0;
      tnew_q[1]    <= s1_v_d ? d_tnew : '0;
      e_a1_q       <= s1_v_d ? d_a1   : '0;
      e_a2_q       <= s1_v_d ? d_a2   : '0;
      e_md_start_q <= s1_md_start_d;
      e_md_div_q   <= s1_md_start_d && d_md_div;
      for (int k = 2; k <= NSTAGE; k++) begin
        v_q[k]    <= v_q[k-1];
        a3_q[k]   <= a3_q[k-1];
        tnew_q[k] <= dec_sat(tnew_q[k-1]);
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] md_stall_cycles_q, md_stall_cycles_d;

  always_comb begin
    stall_cycles_d    = stall_cycles_q;
    md_stall_cycles_d = md_stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (stall_md && (md_stall_cycles_q != 32'hFFFF_FFFF)) begin
      md_stall_cycles_d = md_stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles_q    <= '0;
      md_stall_cycles_q <= '0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      md_stall_cycles_q <= md_stall_cycles_d;
    end
  end

  assign stall_cycles    = stall_cycles_q;
  assign md_stall_cycles = md_stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs queued per driven cycle, popped and compared mid-cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_use_rs, d_use_rt, d_md_use, d_md_start, d_md_div;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .d_valid    (d_valid),
    .d_a1       (d_a1),
    .d_a2       (d_a2),
    .d_use_rs   (d_use_rs),
    .d_tuse_rs  (d_tuse_rs),
    .d_use_rt   (d_use_rt),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .d_md_use   (d_md_use),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .stall      (stall),
    .fwd_rs_d   (fwd_rs_d),
    .fwd_rt_d   (fwd_rt_d),
    .fwd_rs_e   (fwd_rs_e),
    .fwd_rt_e   (fwd_rt_e),
    .md_busy    (md_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] rsd;
    logic [1:0] rtd;
    logic [1:0] rse;
    logic [1:0] rte;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Argument order: valid, a1, a2, use_rs, tuse_rs, use_rt, tuse_rt, a3, tnew, md_use, md_start, md_div
  task automatic drv(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic urs, input logic [1:0] trs, input logic urt, input logic [1:0] trt,
                     input logic [4:0] a3, input logic [1:0] tn,
                     input logic mu, input logic ms, input logic mdiv);
    d_valid = v; d_a1 = a1; d_a2 = a2;
    d_use_rs = urs; d_tuse_rs = trs; d_use_rt = urt; d_tuse_rt = trt;
    d_a3 = a3; d_tnew = tn;
    d_md_use = mu; d_md_start = ms; d_md_div = mdiv;
  endtask

  task automatic bub();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs are already driven; push expectation, compare mid-cycle, then advance one clock.
  task automatic step(input string tag, input logic st, input logic [1:0] rsd, input logic [1:0] rtd,
                      input logic [1:0] rse, input logic [1:0] rte, input logic busy);
    exp_t e;
    e.stall = st; e.rsd = rsd; e.rtd = rtd; e.rse = rse; e.rte = rte; e.busy = busy;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, ".stall"},    32'(stall),    32'(e.stall));
    check({tag, ".fwd_rs_d"}, 32'(fwd_rs_d), 32'(e.rsd));
    check({tag, ".fwd_rt_d"}, 32'(fwd_rt_d), 32'(e.rtd));
    check({tag, ".fwd_rs_e"}, 32'(fwd_rs_e), 32'(e.rse));
    check({tag, ".fwd_rt_e"}, 32'(fwd_rt_e), 32'(e.rte));
    check({tag, ".md_busy"},  32'(md_busy),  32'(e.busy));
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input string tag);
    bub();
    for (int i = 0; i < 3; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bub();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0);

    // lw $1 then dependent addu: one stall, then W->E forward
    drv(1, 2, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0); step("lw_d", 0, 0, 0, 0, 0, 0);
    drv(1, 1, 3, 1, 1, 1, 1, 4, 1, 0, 0, 0); step("addu_stall", 1, 0, 0, 0, 0, 0);
    step("addu_go", 0, 0, 0, 0, 0, 0);
    bub(); step("addu_e", 0, 0, 0, 3, 0, 0);
    flush("flush1");

    // beq $2 behind addu $2 in M
    drv(1, 5, 6, 1, 1, 1, 1, 2, 1, 0, 0, 0); step("t2a_addu", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("t2a_fill", 0, 0, 0, 0, 0, 0);
    drv(1, 2, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("t2a_beq", 0, 2, 0, 0, 0, 0);
    bub(); step("t2a_beq_e", 0, 0, 0, 3, 0, 0);
    flush("flush2");

    // beq $2 behind addu $2 in E and M: youngest wins
    drv(1, 5, 6, 1, 1, 1, 1, 2, 1, 0, 0, 0); step("t2b_addu1", 0, 0, 0, 0, 0, 0);
    drv(1, 2, 6, 1, 1, 1, 1, 2, 1, 0, 0, 0); step("t2b_addu2", 0, 0, 0, 0, 0, 0);
    drv(1, 2, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("t2b_beq_stall", 1, 0, 0, 2, 0, 0);
    step("t2b_beq_go", 0, 2, 0, 0, 0, 0);
    bub(); step("t2b_beq_e", 0, 0, 0, 3, 0, 0);
    flush("flush3");

    // jal then jr $31
    drv(1, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0); step("jal", 0, 0, 0, 0, 0, 0);
    drv(1, 31, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step("jr", 0, 1, 0, 0, 0, 0);
    bub(); step("jr_e", 0, 0, 0, 2, 0, 0);
    flush("flush4");

    // $0 destination never creates a hazard
    drv(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); step("zero_w", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); step("zero_r", 0, 0, 0, 0, 0, 0);
    bub(); step("zero_e", 0, 0, 0, 0, 0, 0);
    flush("flush5");

    // rt hazard: lw $8, reader needs rt in D
    drv(1, 0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0); step("rt_lw", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0); step("rt_s1", 1, 0, 0, 0, 0, 0);
    step("rt_s2", 1, 0, 0, 0, 0, 0);
    step("rt_go", 0, 0, 3, 0, 0, 0);
    bub(); step("rt_e", 0, 0, 0, 0, 0, 0);
    flush("flush6");

    // rt forwarding in D from M, then in E from W
    drv(1, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0); step("rtf_w", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("rtf_fill", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 9, 0, 0, 1, 1, 0, 0, 0, 0, 0); step("rtf_d", 0, 0, 2, 0, 0, 0);
    bub(); step("rtf_e", 0, 0, 0, 0, 3, 0);
    flush("flush7");

    // div then mflo: 1 cycle in stage1 + DIV_LAT busy cycles
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step("div_d", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0); step("mflo_s1", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("mflo_busy", 1, 0, 0, 0, 0, 1);
    step("mflo_go", 0, 0, 0, 0, 0, 0);
    bub(); step("mflo_e", 0, 0, 0, 0, 0, 0);
    flush("flush8");

    // mult, bubble with md_use, then mfhi waits out MUL_LAT
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step("mult_d", 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step("md_bubble", 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 11, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("mfhi_busy", 1, 0, 0, 0, 0, 1);
    step("mfhi_go", 0, 0, 0, 0, 0, 0);
    flush("flush9");

    // reset during the 4th busy cycle of a divide
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); step("rst_div", 0, 0, 0, 0, 0, 0);
    bub(); step("rst_s1", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rst_busy", 0, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0);
    reset_n = 1'b0;
    step("rst_cyc", 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    drv(1, 31, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    check("post_rst.stall_cycles", stall_cycles, 32'd0);
    check("post_rst.md_stall_cycles", md_stall_cycles, 32'd0);
`endif
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
